// File: rtl/apb2mem_pkg.sv
// Shared types and constants for the APB-to-mem bridge.
package apb2mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int unsigned MAX_LATENCY = 3;
  localparam int unsigned CNT_W       = 2;

endpackage

// File: rtl/apb2mem_bridge.sv
// APB3 slave that turns each transfer into one mem_i access of a register file
// and returns the result as a registered APB response.
module apb2mem_bridge
  import apb2mem_pkg::*;
#(
  parameter int unsigned addrwidth = 13,
  parameter int unsigned datawidth = 32,
  parameter int unsigned latency   = 1
) (
  input  logic                   main_clk_i,
  input  logic                   main_rst_i,
  input  logic                   apb_psel_i,
  input  logic                   apb_penable_i,
  input  logic                   apb_pwrite_i,
  input  logic [addrwidth+1:0]   apb_paddr_i,
  input  logic [datawidth-1:0]   apb_pwdata_i,
  output logic                   apb_pready_o,
  output logic [datawidth-1:0]   apb_prdata_o,
  output logic                   apb_pslverr_o,
  output logic                   mem_ena_o,
  output logic [addrwidth-1:0]   mem_addr_o,
  output logic                   mem_wena_o,
  output logic [datawidth-1:0]   mem_wdata_o,
  input  logic [datawidth-1:0]   mem_rdata_i,
  input  logic                   mem_err_i,
  output logic                   busy_o
);

  if (latency < 1 || latency > MAX_LATENCY || datawidth != 32) begin : g_bad_param
    $error("apb2mem_bridge: latency must be 1..3 and datawidth must be 32");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(latency - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pready_q, pready_d;
  logic [datawidth-1:0]   prdata_q, prdata_d;
  logic                   pslverr_q, pslverr_d;
  logic                   mem_ena_q, mem_ena_d;
  logic [addrwidth-1:0]   mem_addr_q, mem_addr_d;
  logic                   mem_wena_q, mem_wena_d;
  logic [datawidth-1:0]   mem_wdata_q, mem_wdata_d;
  logic                   busy_q, busy_d;

  // The mem address/wena/wdata registers double as the capture register:
  // they are loaded at setup and hold until the next accepted access.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pready_d    = 1'b0;
    prdata_d    = '0;
    pslverr_d   = 1'b0;
    mem_ena_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wena_d  = mem_wena_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (apb_psel_i && !apb_penable_i) begin
          if (apb_paddr_i[1:0] != 2'b00) begin
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            state_d     = ST_ISSUE;
            mem_ena_d   = 1'b1;
            mem_addr_d  = apb_paddr_i[addrwidth+1:2];
            mem_wena_d  = apb_pwrite_i;
            mem_wdata_d = apb_pwdata_i;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = apb_psel_i ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        // cnt_q reaching zero marks the cycle exactly latency cycles after ena
        if (!apb_psel_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d   = ST_RESP;
          pready_d  = 1'b1;
          prdata_d  = mem_wena_q ? '0 : mem_rdata_i;
          pslverr_d = mem_err_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pready_q    <= 1'b0;
      prdata_q    <= '0;
      pslverr_q   <= 1'b0;
      mem_ena_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wena_q  <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pready_q    <= pready_d;
      prdata_q    <= prdata_d;
      pslverr_q   <= pslverr_d;
      mem_ena_q   <= mem_ena_d;
      mem_addr_q  <= mem_addr_d;
      mem_wena_q  <= mem_wena_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign apb_pready_o  = pready_q;
  assign apb_prdata_o  = prdata_q;
  assign apb_pslverr_o = pslverr_q;
  assign mem_ena_o     = mem_ena_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wena_o    = mem_wena_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_apb2mem_bridge.sv
// Scoreboard bench for apb2mem_bridge: DUT0 runs latency=1, DUT1 runs latency=3.
module tb_apb2mem_bridge;

  localparam int AW = 13;
  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int unsigned   due;
  } apb_exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wena;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
  } mem_exp_t;

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] rdata;
    logic          err;
  } mem_rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst     [2];
  logic          psel    [2];
  logic          penable [2];
  logic          pwrite  [2];
  logic [AW+1:0] paddr   [2];
  logic [DW-1:0] pwdata  [2];
  logic          pready  [2];
  logic [DW-1:0] prdata  [2];
  logic          pslverr [2];
  logic          ena     [2];
  logic [AW-1:0] maddr   [2];
  logic          wena    [2];
  logic [DW-1:0] mwdata  [2];
  logic [DW-1:0] mrdata  [2];
  logic          merr    [2];
  logic          busy    [2];

  apb2mem_bridge #(.addrwidth(AW), .datawidth(DW), .latency(1)) u_dut0 (
    .main_clk_i(clk), .main_rst_i(rst[0]),
    .apb_psel_i(psel[0]), .apb_penable_i(penable[0]), .apb_pwrite_i(pwrite[0]),
    .apb_paddr_i(paddr[0]), .apb_pwdata_i(pwdata[0]),
    .apb_pready_o(pready[0]), .apb_prdata_o(prdata[0]), .apb_pslverr_o(pslverr[0]),
    .mem_ena_o(ena[0]), .mem_addr_o(maddr[0]), .mem_wena_o(wena[0]),
    .mem_wdata_o(mwdata[0]), .mem_rdata_i(mrdata[0]), .mem_err_i(merr[0]),
    .busy_o(busy[0])
  );

  apb2mem_bridge #(.addrwidth(AW), .datawidth(DW), .latency(3)) u_dut1 (
    .main_clk_i(clk), .main_rst_i(rst[1]),
    .apb_psel_i(psel[1]), .apb_penable_i(penable[1]), .apb_pwrite_i(pwrite[1]),
    .apb_paddr_i(paddr[1]), .apb_pwdata_i(pwdata[1]),
    .apb_pready_o(pready[1]), .apb_prdata_o(prdata[1]), .apb_pslverr_o(pslverr[1]),
    .mem_ena_o(ena[1]), .mem_addr_o(maddr[1]), .mem_wena_o(wena[1]),
    .mem_wdata_o(mwdata[1]), .mem_rdata_i(mrdata[1]), .mem_err_i(merr[1]),
    .busy_o(busy[1])
  );

  int checks = 0;
  int fails  = 0;
  int ena_cnt [2];

  apb_exp_t aq0[$];
  apb_exp_t aq1[$];
  mem_exp_t mq0[$];
  mem_exp_t mq1[$];
  mem_rsp_t rq0[$];
  mem_rsp_t rq1[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // APB side: pop the expected response whenever pready shows up.
  task automatic mon_apb(input int i);
    apb_exp_t e;
    int       n;
    n = (i == 0) ? aq0.size() : aq1.size();
    if (pready[i] === 1'b1) begin
      if (n == 0) begin
        checks++;
        fails++;
        $display("FAIL dut%0d_unexpected_pready: actual 1 required 0 (cycle %0d)", i, cyc);
      end else begin
        if (i == 0) e = aq0.pop_front();
        else        e = aq1.pop_front();
        chk($sformatf("dut%0d_pready_cycle", i), cyc, e.due);
        chk($sformatf("dut%0d_prdata", i), prdata[i], e.rdata);
        chk($sformatf("dut%0d_pslverr", i), {31'd0, pslverr[i]}, {31'd0, e.err});
      end
    end else begin
      chk($sformatf("dut%0d_prdata_idle", i), prdata[i], '0);
      chk($sformatf("dut%0d_pslverr_idle", i), {31'd0, pslverr[i]}, 32'd0);
    end
  endtask

  // Register-file side: check each access, then answer it latency cycles later.
  task automatic mem_model(input int i);
    mem_exp_t m;
    mem_rsp_t r;
    int       n;
    if (ena[i] === 1'b1) begin
      ena_cnt[i]++;
      n = (i == 0) ? mq0.size() : mq1.size();
      if (n == 0) begin
        checks++;
        fails++;
        $display("FAIL dut%0d_unexpected_ena: actual 1 required 0 (cycle %0d)", i, cyc);
      end else begin
        if (i == 0) m = mq0.pop_front();
        else        m = mq1.pop_front();
        chk($sformatf("dut%0d_mem_addr", i), {19'd0, maddr[i]}, {19'd0, m.addr});
        chk($sformatf("dut%0d_mem_wena", i), {31'd0, wena[i]}, {31'd0, m.wena});
        if (m.wena) chk($sformatf("dut%0d_mem_wdata", i), mwdata[i], m.wdata);
        r.due   = cyc + lat(i);
        r.rdata = m.rdata;
        r.err   = m.err;
        if (i == 0) rq0.push_back(r);
        else        rq1.push_back(r);
      end
    end
    n = (i == 0) ? rq0.size() : rq1.size();
    if (n != 0 && ((i == 0) ? rq0[0].due : rq1[0].due) == cyc) begin
      if (i == 0) r = rq0.pop_front();
      else        r = rq1.pop_front();
      mrdata[i] = r.rdata;
      merr[i]   = r.err;
    end else begin
      mrdata[i] = 32'hBAD0_0000 ^ cyc;
      merr[i]   = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      mon_apb(i);
      mem_model(i);
    end
  end

  task automatic chk_zero(input int i, input string tag);
    chk($sformatf("%s_dut%0d_pready", tag, i), {31'd0, pready[i]}, 32'd0);
    chk($sformatf("%s_dut%0d_prdata", tag, i), prdata[i], 32'd0);
    chk($sformatf("%s_dut%0d_pslverr", tag, i), {31'd0, pslverr[i]}, 32'd0);
    chk($sformatf("%s_dut%0d_ena", tag, i), {31'd0, ena[i]}, 32'd0);
    chk($sformatf("%s_dut%0d_addr", tag, i), {19'd0, maddr[i]}, 32'd0);
    chk($sformatf("%s_dut%0d_wena", tag, i), {31'd0, wena[i]}, 32'd0);
    chk($sformatf("%s_dut%0d_wdata", tag, i), mwdata[i], 32'd0);
    chk($sformatf("%s_dut%0d_busy", tag, i), {31'd0, busy[i]}, 32'd0);
  endtask

  // One full APB transfer; returns at the negedge of the pready cycle.
  task automatic xfer(input int i, input logic wr, input logic [AW+1:0] addr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] mem_rd,
                      input logic mem_er, input logic [DW-1:0] exp_rd,
                      input logic exp_err);
    apb_exp_t    a;
    mem_exp_t    m;
    int unsigned t0;
    bit          aligned;
    bit          got;
    aligned = (addr[1:0] == 2'b00);
    @(negedge clk);
    chk($sformatf("dut%0d_busy_setup", i), {31'd0, busy[i]}, 32'd0);
    t0      = cyc;
    a.rdata = exp_rd;
    a.err   = exp_err;
    a.due   = aligned ? t0 + lat(i) + 2 : t0 + 1;
    if (i == 0) aq0.push_back(a);
    else        aq1.push_back(a);
    if (aligned) begin
      m.addr  = addr[AW+1:2];
      m.wena  = wr;
      m.wdata = wd;
      m.rdata = mem_rd;
      m.err   = mem_er;
      if (i == 0) mq0.push_back(m);
      else        mq1.push_back(m);
    end
    psel[i]    = 1'b1;
    penable[i] = 1'b0;
    pwrite[i]  = wr;
    paddr[i]   = addr;
    pwdata[i]  = wd;
    @(negedge clk);
    chk($sformatf("dut%0d_busy_access", i), {31'd0, busy[i]}, 32'd1);
    penable[i] = 1'b1;
    paddr[i]   = ~addr;
    pwdata[i]  = ~wd;
    pwrite[i]  = ~wr;
    got = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (pready[i] === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL dut%0d_pready_timeout: actual 0 required 1 within 12 cycles", i);
    end else begin
      chk($sformatf("dut%0d_busy_resp", i), {31'd0, busy[i]}, 32'd1);
    end
  endtask

  task automatic apb_idle(input int i);
    @(negedge clk);
    psel[i]    = 1'b0;
    penable[i] = 1'b0;
  endtask

  int c;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = '0; pwdata[i] = '0; ena_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk_zero(0, "reset");
    chk_zero(1, "reset");
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // aligned read, latency 1
    xfer(0, 1'b0, 15'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
    apb_idle(0);

    // write answered with error, latency 3: prdata forced to 0
    xfer(1, 1'b1, 15'h7FFC, 32'h12345678, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1);
    apb_idle(1);

    // misaligned read: no mem access, immediate error
    c = ena_cnt[0];
    xfer(0, 1'b0, 15'h0002, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    apb_idle(0);
    chk("misaligned_ena_count", ena_cnt[0], c);

    // back-to-back reads to words 1 and 2
    c = ena_cnt[0];
    xfer(0, 1'b0, 15'h0004, 32'h0, 32'h11111111, 1'b0, 32'h11111111, 1'b0);
    xfer(0, 1'b0, 15'h0008, 32'h0, 32'h22222222, 1'b0, 32'h22222222, 1'b0);
    apb_idle(0);
    chk("b2b_ena_count", ena_cnt[0], c + 2);

    // access phase without setup is ignored
    c = ena_cnt[0];
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 15'h0010; pwrite[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("noset_busy", {31'd0, busy[0]}, 32'd0);
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    chk("noset_ena_count", ena_cnt[0], c);

    // abort in WAIT on the latency-3 bridge
    @(negedge clk);
    begin
      mem_exp_t m;
      m.addr = 13'h0010; m.wena = 1'b0; m.wdata = '0; m.rdata = 32'hAAAA5555; m.err = 1'b0;
      mq1.push_back(m);
    end
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 15'h0040;
    @(negedge clk);
    penable[1] = 1'b1;
    @(negedge clk);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy[1]}, 32'd0);
    xfer(1, 1'b0, 15'h0044, 32'h0, 32'h55AA33CC, 1'b0, 32'h55AA33CC, 1'b0);
    apb_idle(1);

    // one-cycle reset during WAIT; the late mem response must be dropped
    @(negedge clk);
    begin
      mem_exp_t m;
      m.addr = 13'h0020; m.wena = 1'b0; m.wdata = '0; m.rdata = 32'hFEEDFACE; m.err = 1'b1;
      mq1.push_back(m);
    end
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 15'h0080;
    @(negedge clk);
    penable[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    chk_zero(1, "midreset");
    repeat (4) begin
      @(negedge clk);
      chk("midreset_prdata", prdata[1], 32'h0);
    end
    xfer(1, 1'b0, 15'h0084, 32'h0, 32'h0F0F1234, 1'b0, 32'h0F0F1234, 1'b0);
    apb_idle(1);

    repeat (6) @(negedge clk);
    chk("dut0_apb_queue_empty", aq0.size(), 0);
    chk("dut1_apb_queue_empty", aq1.size(), 0);
    chk("dut0_mem_queue_empty", mq0.size(), 0);
    chk("dut1_mem_queue_empty", mq1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: actual still running required finished");
    $fatal(1, "timeout");
  end

endmodule
